miner_core_msa_stream: RTL and testbench
========================================

Name: miner_core_msa_stream

Overview:
Parametrised streaming message scheduler for the miner core. It accepts one message block and emits the expanded schedule W[0..ROUNDS-1], one word per handshake, to the compression rounds. It keeps only a 16-word sliding window instead of a full 64-word array. It supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) via a parameter, with output backpressure, abort, and back-to-back block loading.

Parameters:
WORD_W, 32, word width; legal values are 32 (SHA-256 sigmas) and 64 (SHA-512 sigmas).
ROUNDS, 64, number of schedule words emitted per block; must be at least 17; use 80 when WORD_W=64.
IDX_W, 7, width of the word index output; must satisfy 2^IDX_W >= ROUNDS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
abort  input  1  synchronous flush of the block in progress.
load_valid  input  1  a block is presented on block_in.
load_ready  output  1  block can be accepted this cycle.
block_in  input  16*WORD_W  message block; word 0 in the most significant WORD_W bits.
w_valid  output  1  w_data holds a valid schedule word.
w_ready  input  1  consumer accepts w_data this cycle.
w_data  output  WORD_W  schedule word W[w_idx].
w_idx  output  IDX_W  index t of the current word.
w_last  output  1  high with the word where t = ROUNDS-1.
busy  output  1  high while a block is in progress.

Behaviour:
- Reset and clock: one clock (clk); asynchronous, active-high reset (rst).
- Reset values: state IDLE, window all zero, w_idx=0, w_valid=0, w_last=0, busy=0, w_data=0, load_ready=1.
- Registers: 16 x WORD_W window win[0..15], index counter idx, state register. w_data = win[0] and w_idx = idx, both straight from registers with no combinational arithmetic on w_data.
- State IDLE:
  - load_ready=1, w_valid=0.
  - On load_valid: win[i] <= block word i, idx <= 0, go to RUN.
- State RUN:
  - w_valid=1, busy=1.
  - w_last = (idx == ROUNDS-1).
- Transfer (w_valid & w_ready):
  - Window shifts: win[i] <= win[i+1] for i = 0..14.
  - win[15] <= sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], modulo 2^WORD_W.
  - idx <= idx + 1.
- No transfer (w_ready=0 in RUN): window, idx, and outputs hold unchanged. Consumer may stall any number of cycles.
- Sigma functions:
  - WORD_W=32: sigma0 = ROTR7 ^ ROTR18 ^ SHR3; sigma1 = ROTR17 ^ ROTR19 ^ SHR10.
  - WORD_W=64: sigma0 = ROTR1 ^ ROTR8 ^ SHR7; sigma1 = ROTR19 ^ ROTR61 ^ SHR6.
- Latency: the first word is valid on the cycle after the load handshake. With w_ready held high, throughput is one word per cycle.
- Last word: on transfer with w_last=1, go to IDLE, w_valid falls, idx <= 0. Words computed beyond ROUNDS-1 are discarded.
- Back-to-back loads:
  - load_ready = IDLE | (w_valid & w_ready & w_last).
  - A load coincident with the last transfer overwrites the window with the new block, sets idx=0, and stays in RUN. There is no bubble between blocks.
- Abort:
  - Abort has priority over transfer and load. The next state is IDLE with idx=0; the window is not cleared.
  - load_ready is forced to 0 in any cycle abort is high.
- load_valid while not load_ready: ignored; block_in is not sampled.
- rst mid-block: immediate return to the reset values. No partial word is emitted after rst is released.
- idx never wraps within a block; it is bounded by ROUNDS-1.

Test Plan:
1. SHA-256 padded "abc" (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> words t=0..15 echo the block, t=16 = 0x61626380, t=17 = 0x000F0000, w_last only at t=63, then IDLE.
2. Same block with w_ready toggled in a pseudo-random pattern -> identical 64-word sequence as scenario 1, no duplicated or skipped indices, w_data stable while stalled.
3. Two blocks back-to-back, second load_valid asserted with the last transfer -> 128 consecutive valid cycles; w_idx goes 63 -> 0 with no bubble; second block's W16 is correct.
4. Abort asserted at t=20 while stalled -> next cycle w_valid=0, busy=0, load_ready=1; a fresh load restarts at t=0 with correct words.
5. rst pulsed at t=40 -> outputs take their reset values asynchronously; after release load_ready=1 and no valid word appears until a new load.
6. WORD_W=64, ROUNDS=80, SHA-512 padded "abc" (W0=0x6162638000000000, W15=0x18) -> 80 words emitted, w_last at t=79, and W16 equals the golden-model value.

Source files
------------

// File: rtl/miner_core_msa_stream_if.sv
// Handshake bundle between the streaming message scheduler, its block loader
// and the compression-round consumer.
interface miner_core_msa_stream_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 7
);
    logic                 abort;
    logic                 load_valid;
    logic                 load_ready;
    logic [16*WORD_W-1:0] block_in;
    logic                 w_valid;
    logic                 w_ready;
    logic [WORD_W-1:0]    w_data;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_last;
    logic                 busy;

    modport master (
        output abort, load_valid, block_in, w_ready,
        input  load_ready, w_valid, w_data, w_idx, w_last, busy
    );

    modport slave (
        input  abort, load_valid, block_in, w_ready,
        output load_ready, w_valid, w_data, w_idx, w_last, busy
    );
endinterface

// File: rtl/miner_core_msa_stream.sv
// Streaming SHA-2 message scheduler: expands one 16-word block into ROUNDS
// schedule words using a 16-word sliding window, one word per handshake.
module miner_core_msa_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    miner_core_msa_stream_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_win [16];
    logic [IDX_W-1:0]  r_idx;

    logic              w_run;
    logic              w_last;
    logic              w_xfer;
    logic              w_load_ready;
    logic              w_load;
    logic [WORD_W-1:0] w_new;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign w_run        = (r_state == S_RUN);
    assign w_last       = w_run && (r_idx == IDX_W'(ROUNDS - 1));
    assign w_xfer       = w_run && bus.w_ready;
    // A new block may replace the one whose last word is leaving this cycle.
    assign w_load_ready = !bus.abort && (!w_run || (w_xfer && w_last));
    assign w_load       = bus.load_valid && w_load_ready;
    assign w_new        = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort)
            w_state_nxt = S_IDLE;
        else if (w_load)
            w_state_nxt = S_RUN;
        else if (w_xfer && w_last)
            w_state_nxt = S_IDLE;
    end

    // NOTE: the window is a bank of flops rather than a RAM, so it takes the
    // async reset together with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.abort) begin
                r_idx <= '0;
            end else if (w_load) begin
                r_idx <= '0;
                for (int i = 0; i < 16; i++)
                    r_win[i] <= bus.block_in[(15 - i)*WORD_W +: WORD_W];
            end else if (w_xfer) begin
                for (int i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
                r_win[15] <= w_new;
                r_idx     <= w_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.w_valid    = w_run;
    assign bus.busy       = w_run;
    assign bus.w_last     = w_last;
    assign bus.w_data     = r_win[0];
    assign bus.w_idx      = r_idx;
endmodule

// File: tb/tb_miner_core_msa_stream.sv
// Scoreboard bench for the streaming scheduler: SHA-256 and SHA-512 instances
// checked against a full-array schedule model with random blocks and backpressure.
module tb_miner_core_msa_stream;
    typedef struct {
        logic [63:0] data;
        int          idx;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    miner_core_msa_stream_if #(.WORD_W(32), .IDX_W(7)) if32 ();
    miner_core_msa_stream_if #(.WORD_W(64), .IDX_W(7)) if64 ();

    miner_core_msa_stream #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (if32.slave)
    );

    miner_core_msa_stream #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (if64.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q32[$];
    exp_t        q64[$];
    logic [63:0] seen32 [80];
    logic [63:0] seen64 [80];
    bit          stall32_f = 1'b0;
    bit          stall64_f = 1'b0;
    logic [63:0] stall32_d;
    logic [63:0] stall64_d;
    logic [63:0] abc32 [16];
    logic [63:0] abc64 [16];
    logic [63:0] blk_a [16];
    logic [63:0] blk_b [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference model: the whole schedule array computed from the SHA-2 recurrence.
    function automatic logic [63:0] msk(input int ww);
        return (ww == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
        return ((x >> n) | (x << (ww - n))) & msk(ww);
    endfunction

    function automatic logic [63:0] s0(input logic [63:0] x, input int ww);
        if (ww == 64) return rotr(x, 1, ww) ^ rotr(x, 8, ww) ^ (x >> 7);
        return rotr(x, 7, ww) ^ rotr(x, 18, ww) ^ (x >> 3);
    endfunction

    function automatic logic [63:0] s1(input logic [63:0] x, input int ww);
        if (ww == 64) return rotr(x, 19, ww) ^ rotr(x, 61, ww) ^ (x >> 6);
        return rotr(x, 17, ww) ^ rotr(x, 19, ww) ^ (x >> 10);
    endfunction

    task automatic push_block(input int ww, input logic [63:0] blk [16]);
        logic [63:0] w [80];
        int          rounds = (ww == 64) ? 80 : 64;
        exp_t        e;
        for (int t = 0; t < rounds; t++) begin
            if (t < 16) w[t] = blk[t] & msk(ww);
            else w[t] = (s1(w[t-2], ww) + w[t-7] + s0(w[t-15], ww) + w[t-16]) & msk(ww);
            e.data = w[t];
            e.idx  = t;
            e.last = (t == rounds - 1);
            if (ww == 64) q64.push_back(e);
            else q32.push_back(e);
        end
    endtask

    task automatic rand_blk(output logic [63:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int ww, input logic [63:0] blk [16]);
        int b = 0;
        for (int i = 0; i < 16; i++) begin
            if (ww == 64) if64.block_in[(15 - i)*64 +: 64] = blk[i];
            else          if32.block_in[(15 - i)*32 +: 32] = blk[i][31:0];
        end
        push_block(ww, blk);
        if (ww == 64) if64.load_valid = 1'b1;
        else          if32.load_valid = 1'b1;
        while (!((ww == 64) ? if64.load_ready : if32.load_ready) && b < 200) begin
            step();
            b++;
        end
        if (b >= 200) fail("load_timeout");
        step();
        if (ww == 64) begin
            if64.load_valid = 1'b0;
            check("first_valid64", 64'(if64.w_valid), 64'd1);
            check("first_idx64", 64'(if64.w_idx), 64'd0);
        end else begin
            if32.load_valid = 1'b0;
            check("first_valid32", 64'(if32.w_valid), 64'd1);
            check("first_idx32", 64'(if32.w_idx), 64'd0);
        end
    endtask

    task automatic drain(input int ww, input bit rnd, input int budget);
        int b = 0;
        while (((ww == 64) ? if64.w_valid : if32.w_valid) && b < budget) begin
            if (ww == 64) if64.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            else          if32.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            b++;
        end
        if (b >= budget) fail("drain_timeout");
        if32.w_ready = 1'b1;
        if64.w_ready = 1'b1;
    endtask

    // Monitors: pop an expected word on every transfer, and require w_data to hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if32.w_valid) begin
            if (stall32_f) check("stall_hold32", 64'(if32.w_data), stall32_d);
            if (if32.w_ready) begin
                stall32_f = 1'b0;
                if (q32.size() == 0) fail("extra_word32");
                else begin
                    e = q32.pop_front();
                    check("w_data32", 64'(if32.w_data), e.data);
                    check("w_idx32", 64'(if32.w_idx), 64'(e.idx));
                    check("w_last32", 64'(if32.w_last), 64'(e.last));
                    seen32[e.idx] = 64'(if32.w_data);
                end
            end else begin
                stall32_f = 1'b1;
                stall32_d = 64'(if32.w_data);
            end
        end else stall32_f = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if64.w_valid) begin
            if (stall64_f) check("stall_hold64", if64.w_data, stall64_d);
            if (if64.w_ready) begin
                stall64_f = 1'b0;
                if (q64.size() == 0) fail("extra_word64");
                else begin
                    e = q64.pop_front();
                    check("w_data64", if64.w_data, e.data);
                    check("w_idx64", 64'(if64.w_idx), 64'(e.idx));
                    check("w_last64", 64'(if64.w_last), 64'(e.last));
                    seen64[e.idx] = if64.w_data;
                end
            end else begin
                stall64_f = 1'b1;
                stall64_d = if64.w_data;
            end
        end else stall64_f = 1'b0;
    end

    initial begin
        int b;
        int cnt;
        bit acc;
        for (int i = 0; i < 16; i++) begin
            abc32[i] = '0;
            abc64[i] = '0;
        end
        abc32[0]  = 64'h0000_0000_6162_6380;
        abc32[15] = 64'h18;
        abc64[0]  = 64'h6162_6380_0000_0000;
        abc64[15] = 64'h18;

        rst = 1'b1;
        if32.abort = 1'b0; if32.load_valid = 1'b0; if32.w_ready = 1'b1; if32.block_in = '0;
        if64.abort = 1'b0; if64.load_valid = 1'b0; if64.w_ready = 1'b1; if64.block_in = '0;
        #12;
        check("rst_w_valid", 64'(if32.w_valid), 64'd0);
        check("rst_busy", 64'(if32.busy), 64'd0);
        check("rst_w_last", 64'(if32.w_last), 64'd0);
        check("rst_w_idx", 64'(if32.w_idx), 64'd0);
        check("rst_w_data", 64'(if32.w_data), 64'd0);
        check("rst_load_ready", 64'(if32.load_ready), 64'd1);
        check("rst_load_ready64", 64'(if64.load_ready), 64'd1);
        @(negedge clk) rst = 1'b0;
        step();

        // Padded "abc", full throughput
        start(32, abc32);
        drain(32, 1'b0, 200);
        check("abc_w16", seen32[16], 64'h6162_6380);
        check("abc_w17", seen32[17], 64'h000F_0000);
        check("idle_w_valid", 64'(if32.w_valid), 64'd0);
        check("idle_busy", 64'(if32.busy), 64'd0);
        check("idle_load_ready", 64'(if32.load_ready), 64'd1);

        // Same block under random backpressure
        start(32, abc32);
        drain(32, 1'b1, 1000);

        // Back-to-back blocks: second load held pending until the last transfer
        rand_blk(blk_a);
        rand_blk(blk_b);
        start(32, blk_a);
        for (int i = 0; i < 16; i++) if32.block_in[(15 - i)*32 +: 32] = blk_b[i][31:0];
        push_block(32, blk_b);
        if32.load_valid = 1'b1;
        cnt = 0;
        for (int c = 0; c < 300 && if32.w_valid; c++) begin
            cnt++;
            acc = if32.load_valid && if32.load_ready;
            step();
            if (acc) if32.load_valid = 1'b0;
        end
        if32.load_valid = 1'b0;
        check("b2b_valid_cycles", 64'(cnt), 64'd128);

        // Abort at t=20 while stalled, with a competing load that must be ignored
        rand_blk(blk_a);
        start(32, blk_a);
        b = 0;
        while (if32.w_idx != 7'd20 && b < 100) begin step(); b++; end
        if (b >= 100) fail("reach_t20_timeout");
        if32.w_ready = 1'b0;
        step();
        step();
        if32.abort = 1'b1;
        if32.load_valid = 1'b1;
        #1;
        check("abort_load_ready", 64'(if32.load_ready), 64'd0);
        step();
        if32.abort = 1'b0;
        if32.load_valid = 1'b0;
        #1;
        check("abort_w_valid", 64'(if32.w_valid), 64'd0);
        check("abort_busy", 64'(if32.busy), 64'd0);
        check("abort_load_ready_after", 64'(if32.load_ready), 64'd1);
        q32.delete();
        if32.w_ready = 1'b1;
        rand_blk(blk_b);
        start(32, blk_b);
        drain(32, 1'b1, 1000);

        // Reset mid-block at t=40
        rand_blk(blk_a);
        start(32, blk_a);
        b = 0;
        while (if32.w_idx != 7'd40 && b < 100) begin step(); b++; end
        if (b >= 100) fail("reach_t40_timeout");
        rst = 1'b1;
        #1;
        check("mid_rst_w_valid", 64'(if32.w_valid), 64'd0);
        check("mid_rst_busy", 64'(if32.busy), 64'd0);
        check("mid_rst_w_idx", 64'(if32.w_idx), 64'd0);
        check("mid_rst_w_data", 64'(if32.w_data), 64'd0);
        check("mid_rst_w_last", 64'(if32.w_last), 64'd0);
        q32.delete();
        step();
        step();
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("post_rst_no_valid", 64'(if32.w_valid), 64'd0);
        end
        check("post_rst_load_ready", 64'(if32.load_ready), 64'd1);
        start(32, abc32);
        drain(32, 1'b0, 200);

        // SHA-512 width, 80 rounds
        start(64, abc64);
        drain(64, 1'b0, 300);
        check("abc512_w16", seen64[16], 64'h6162_6380_0000_0000);
        check("idle64_w_valid", 64'(if64.w_valid), 64'd0);
        rand_blk(blk_a);
        start(64, blk_a);
        drain(64, 1'b1, 1200);

        step();
        check("q32_empty", 64'(q32.size()), 64'd0);
        check("q64_empty", 64'(q64.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
